accum_bank: RTL and testbench
=============================

Name: accum_bank

Overview:
- Parametrised successor to the lab's single 17-bit switch accumulator.
- Holds NUM_ACC independent WIDTH-bit accumulators, each with its own carry/borrow flag.
- Supports ADD, SUB, LOAD and CLEAR, executed once per Run press.
- ADD/SUB run through a slice-serial adder (SLICE bits per cycle) to cut adder area. Sits between the button/switch conditioning logic and the HexDriver/LED display logic.

Parameters:
- WIDTH, 16: accumulator width in bits; must be a multiple of SLICE.
- IN_WIDTH, 10: switch operand width; IN_WIDTH <= WIDTH.
- NUM_ACC, 4: number of accumulators; must be >= 2.
- SLICE, 4: bits processed per CALC cycle.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Run  in  1  active-high level, already inverted from the push button upstream.
- Op  in  2  operation code: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- Sel  in  $clog2(NUM_ACC)  target/display accumulator index.
- Din  in  IN_WIDTH  operand; zero-extended to WIDTH.
- Acc_Out  out  WIDTH  contents of accumulator[Sel], combinational mux on live Sel.
- Carry_Out  out  1  flag of accumulator[Sel], same mux.
- Busy  out  1  high while state is CALC.
- Done  out  1  one-cycle pulse when an operation commits.

Behaviour:
- States: IDLE, CALC, HOLD. Define N = WIDTH/SLICE.
- Reset:
  - All accumulators and flags go to 0; slice counter and operand registers are cleared.
  - Busy=0, Done=0, so Acc_Out=0 and Carry_Out=0.
  - State goes to HOLD, so a Run held through reset does not fire.
  - Reset mid-CALC aborts the operation: no commit, no Done.
- IDLE with Run=1 (edge n): latch Op, Sel and zero-extended Din into operand registers. Later changes to Op, Sel or Din do not affect this operation.
  - ADD/SUB: state goes to CALC, slice counter = 0, carry register = 1 for SUB and 0 for ADD.
  - LOAD: at edge n, acc[Sel] = Din_ext and flag = 0. Done=1 in the following cycle; state goes to HOLD.
  - CLEAR: at edge n, acc[Sel] = 0 and flag = 0. Done=1 in the following cycle; state goes to HOLD.
- CALC (edges n+1 .. n+N): slice k covers bits [k*SLICE +: SLICE].
  - {c, r} = acc[k] + (B[k] XOR {SLICE{sub}}) + c.
  - Each result slice is written to a shadow result register.
  - Acc_Out keeps showing the old value until commit; the commit is atomic.
  - At edge n+N: acc[latched Sel] = shadow result. Flag = final carry for ADD, or NOT final carry (borrow) for SUB. Done=1 for one cycle; state goes to HOLD.
  - Latency: ADD/SUB commit N edges after the triggering edge, LOAD/CLEAR on the triggering edge. Busy is high for exactly N cycles.
- HOLD: stay while Run=1; go to IDLE when Run=0. One press gives exactly one operation, regardless of how long Run is held.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - ADD flag = 1 iff the unsigned sum is >= 2^WIDTH.
  - SUB flag = 1 iff Din_ext > acc before the operation.
  - The flag is overwritten by every operation on that accumulator, not sticky.
- Only accumulator[latched Sel] changes; all others are untouched.
- Done is never asserted in two consecutive cycles.

Test Plan:
- Reset; Sel=0, Op=ADD, Din=0x3FF, Run high for 1 cycle -> Busy high 4 cycles, then Done pulses once, Acc_Out=0x03FF, Carry_Out=0.
- Sel=0, ADD Din=0x001 with Run held 20 cycles -> exactly one Done, Acc_Out=0x0400. After release and a second press -> 0x0401.
- CLEAR acc0; SUB Din=0x001 -> Acc_Out=0xFFFF, Carry_Out=1. Then ADD Din=0x001 -> Acc_Out=0x0000, Carry_Out=1. Then LOAD 0x155 -> 0x0155, Carry_Out=0.
- Sel=1 LOAD 0x155; Sel=2 ADD 0x0AA; sweep Sel 0..3 -> 0x0000, 0x0155, 0x00AA, 0x0000.
- Start ADD Din=0x00F on Sel=1; during CALC change Din=0x3FF and Sel=3 -> acc1 += 0x00F, acc3 unchanged.
- Reset asserted on the 2nd CALC cycle with Run held -> all Acc_Out=0, no Done, Busy=0. No operation until Run drops and is pressed again.

Source files
------------

// File: rtl/accum_bank.sv
// Bank of NUM_ACC accumulators driven by Run presses; ADD/SUB go through a
// slice-serial adder and commit atomically, LOAD/CLEAR commit immediately.
module accum_bank #(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = 10,
  parameter int NUM_ACC  = 4,
  parameter int SLICE    = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Run,
  input  logic [1:0]                 Op,
  input  logic [$clog2(NUM_ACC)-1:0] Sel,
  input  logic [IN_WIDTH-1:0]        Din,
  output logic [WIDTH-1:0]           Acc_Out,
  output logic                       Carry_Out,
  output logic                       Busy,
  output logic                       Done
);

  localparam int N     = WIDTH / SLICE;
  localparam int SEL_W = $clog2(NUM_ACC);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR} op_t;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] acc [NUM_ACC];
  logic             flag [NUM_ACC];

  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] opnd_q;
  logic             sub_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic             done_q;

  logic [WIDTH-1:0] din_ext;
  logic [WIDTH-1:0] acc_sel;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] next_shadow;

  assign din_ext   = WIDTH'(Din);
  assign acc_sel   = acc[sel_q];
  assign Acc_Out   = acc[Sel];
  assign Carry_Out = flag[Sel];

  always_ff @(posedge Clk) begin
    if (Reset) state <= HOLD;
    else       state <= next_state;
  end

  // HOLD waits for Run to drop so one press yields exactly one operation
  always_comb begin
    next_state = state;
    Busy       = (state == CALC);
    Done       = done_q;
    case (state)
      IDLE: if (Run) next_state = ((Op == OP_ADD) || (Op == OP_SUB)) ? CALC : HOLD;
      CALC: if (cnt == LAST) next_state = HOLD;
      HOLD: if (!Run) next_state = IDLE;
      default: next_state = HOLD;
    endcase
  end

  // One SLICE-wide add per cycle; SUB inverts the operand and seeds carry=1
  always_comb begin
    a_slice     = '0;
    b_slice     = '0;
    next_shadow = shadow;
    for (int k = 0; k < N; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_slice = acc_sel[k*SLICE +: SLICE];
        b_slice = opnd_q[k*SLICE +: SLICE] ^ {SLICE{sub_q}};
      end
    end
    sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
    for (int k = 0; k < N; k++) begin
      if (cnt == CNT_W'(k)) next_shadow[k*SLICE +: SLICE] = sum[SLICE-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc[i]  <= '0;
        flag[i] <= 1'b0;
      end
      sel_q   <= '0;
      opnd_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      shadow  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Run) begin
            sel_q   <= Sel;
            opnd_q  <= din_ext;
            sub_q   <= (Op == OP_SUB);
            carry_q <= (Op == OP_SUB);
            cnt     <= '0;
            shadow  <= '0;
            if (Op == OP_LOAD) begin
              acc[Sel]  <= din_ext;
              flag[Sel] <= 1'b0;
              done_q    <= 1'b1;
            end else if (Op == OP_CLEAR) begin
              acc[Sel]  <= '0;
              flag[Sel] <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        CALC: begin
          shadow  <= next_shadow;
          carry_q <= sum[SLICE];
          cnt     <= cnt + 1'b1;
          // Final slice: commit the whole result at once; SUB flag is the borrow
          if (cnt == LAST) begin
            acc[sel_q]  <= next_shadow;
            flag[sel_q] <= sub_q ? ~sum[SLICE] : sum[SLICE];
            done_q      <= 1'b1;
            cnt         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: each task drives one scenario and checks
// Acc_Out/Carry_Out/Busy/Done against hand-computed values.
module tb_accum_bank;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic [1:0]  Op;
  logic [1:0]  Sel;
  logic [9:0]  Din;
  logic [15:0] Acc_Out;
  logic        Carry_Out;
  logic        Busy;
  logic        Done;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  accum_bank #(.WIDTH(16), .IN_WIDTH(10), .NUM_ACC(4), .SLICE(4)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Op(Op), .Sel(Sel), .Din(Din),
    .Acc_Out(Acc_Out), .Carry_Out(Carry_Out), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Press Run for 'hold' cycles, then watch a fixed window counting Busy/Done
  task automatic do_op(input logic [1:0] op, input logic [1:0] sel,
                       input logic [9:0] din, input int hold,
                       output int busy_n, output int done_n);
    @(negedge Clk);
    Op = op; Sel = sel; Din = din; Run = 1'b1;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < hold + 10; i++) begin
      @(negedge Clk);
      if (Busy) busy_n++;
      if (Done) done_n++;
      if (i + 1 >= hold) Run = 1'b0;
    end
  endtask

  task automatic test_reset;
    int dn;
    Reset = 1'b1; Run = 1'b1; Op = ADD; Sel = 2'd0; Din = 10'h3FF;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    vec_cnt++;
    if (Acc_Out !== 16'h0000) begin miss_cnt++; $display("[TB] FAIL reset_acc got %h want 0000", Acc_Out); end
    vec_cnt++;
    if (Carry_Out !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_carry got %b want 0", Carry_Out); end
    vec_cnt++;
    if (Busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    vec_cnt++;
    if (dn != 0) begin miss_cnt++; $display("[TB] FAIL reset_run_held_done got %0d want 0", dn); end
    Run = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_add_basic;
    int bn, dn;
    do_op(ADD, 2'd0, 10'h3FF, 1, bn, dn);
    vec_cnt++;
    if (bn != 4) begin miss_cnt++; $display("[TB] FAIL add_busy_cycles got %0d want 4", bn); end
    vec_cnt++;
    if (dn != 1) begin miss_cnt++; $display("[TB] FAIL add_done_count got %0d want 1", dn); end
    vec_cnt++;
    if (Acc_Out !== 16'h03FF) begin miss_cnt++; $display("[TB] FAIL add_acc got %h want 03ff", Acc_Out); end
    vec_cnt++;
    if (Carry_Out !== 1'b0) begin miss_cnt++; $display("[TB] FAIL add_carry got %b want 0", Carry_Out); end
  endtask

  task automatic test_run_held;
    int bn, dn;
    do_op(ADD, 2'd0, 10'h001, 20, bn, dn);
    vec_cnt++;
    if (dn != 1) begin miss_cnt++; $display("[TB] FAIL held_done_count got %0d want 1", dn); end
    vec_cnt++;
    if (Acc_Out !== 16'h0400) begin miss_cnt++; $display("[TB] FAIL held_acc got %h want 0400", Acc_Out); end
    do_op(ADD, 2'd0, 10'h001, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h0401) begin miss_cnt++; $display("[TB] FAIL second_press_acc got %h want 0401", Acc_Out); end
  endtask

  task automatic test_sub_wrap;
    int bn, dn;
    do_op(CLR, 2'd0, 10'h155, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h0000 || dn != 1 || bn != 0) begin
      miss_cnt++; $display("[TB] FAIL clear got acc=%h done=%0d busy=%0d want 0000/1/0", Acc_Out, dn, bn);
    end
    do_op(SUB, 2'd0, 10'h001, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'hFFFF || Carry_Out !== 1'b1) begin
      miss_cnt++; $display("[TB] FAIL sub_borrow got %h/%b want ffff/1", Acc_Out, Carry_Out);
    end
    do_op(ADD, 2'd0, 10'h001, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h0000 || Carry_Out !== 1'b1) begin
      miss_cnt++; $display("[TB] FAIL add_overflow got %h/%b want 0000/1", Acc_Out, Carry_Out);
    end
    do_op(LOAD, 2'd0, 10'h155, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h0155 || Carry_Out !== 1'b0 || dn != 1) begin
      miss_cnt++; $display("[TB] FAIL load got %h/%b done=%0d want 0155/0/1", Acc_Out, Carry_Out, dn);
    end
    do_op(SUB, 2'd0, 10'h055, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h0100 || Carry_Out !== 1'b0) begin
      miss_cnt++; $display("[TB] FAIL sub_plain got %h/%b want 0100/0", Acc_Out, Carry_Out);
    end
    do_op(SUB, 2'd0, 10'h100, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h0000 || Carry_Out !== 1'b0) begin
      miss_cnt++; $display("[TB] FAIL sub_equal got %h/%b want 0000/0", Acc_Out, Carry_Out);
    end
  endtask

  task automatic test_multi_acc;
    int bn, dn;
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'h0000; exp_tab[1] = 16'h0155; exp_tab[2] = 16'h00AA; exp_tab[3] = 16'h0000;
    do_op(CLR, 2'd0, 10'h000, 1, bn, dn);
    do_op(LOAD, 2'd1, 10'h155, 1, bn, dn);
    do_op(ADD, 2'd2, 10'h0AA, 1, bn, dn);
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      #1;
      vec_cnt++;
      if (Acc_Out !== exp_tab[s]) begin
        miss_cnt++; $display("[TB] FAIL sweep_sel%0d got %h want %h", s, Acc_Out, exp_tab[s]);
      end
    end
  endtask

  task automatic test_operand_latch;
    int dn;
    @(negedge Clk);
    Op = ADD; Sel = 2'd1; Din = 10'h00F; Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0; Din = 10'h3FF; Sel = 2'd3;
    @(negedge Clk);
    Sel = 2'd1;
    #1;
    vec_cnt++;
    if (Acc_Out !== 16'h0155) begin miss_cnt++; $display("[TB] FAIL atomic_during_calc got %h want 0155", Acc_Out); end
    dn = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    vec_cnt++;
    if (Acc_Out !== 16'h0164 || Carry_Out !== 1'b0 || dn != 1) begin
      miss_cnt++; $display("[TB] FAIL latch_acc1 got %h/%b done=%0d want 0164/0/1", Acc_Out, Carry_Out, dn);
    end
    Sel = 2'd3;
    #1;
    vec_cnt++;
    if (Acc_Out !== 16'h0000) begin miss_cnt++; $display("[TB] FAIL latch_acc3 got %h want 0000", Acc_Out); end
  endtask

  task automatic test_reset_mid_calc;
    int bn, dn;
    @(negedge Clk);
    Op = ADD; Sel = 2'd1; Din = 10'h00F; Run = 1'b1;
    @(negedge Clk);
    vec_cnt++;
    if (Busy !== 1'b1) begin miss_cnt++; $display("[TB] FAIL midcalc_busy got %b want 1", Busy); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bn = 0; dn = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Busy) bn++;
      if (Done) dn++;
    end
    vec_cnt++;
    if (bn != 0 || dn != 0) begin
      miss_cnt++; $display("[TB] FAIL abort_activity got busy=%0d done=%0d want 0/0", bn, dn);
    end
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      #1;
      vec_cnt++;
      if (Acc_Out !== 16'h0000 || Carry_Out !== 1'b0) begin
        miss_cnt++; $display("[TB] FAIL abort_clear_sel%0d got %h/%b want 0000/0", s, Acc_Out, Carry_Out);
      end
    end
    Run = 1'b0;
    do_op(LOAD, 2'd0, 10'h2A5, 1, bn, dn);
    vec_cnt++;
    if (Acc_Out !== 16'h02A5 || dn != 1) begin
      miss_cnt++; $display("[TB] FAIL after_abort_load got %h done=%0d want 02a5/1", Acc_Out, dn);
    end
  endtask

  initial begin
    test_reset;
    test_add_basic;
    test_run_held;
    test_sub_wrap;
    test_multi_acc;
    test_operand_latch;
    test_reset_mid_calc;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
